// File: rtl/riscv_i32_pipeline_debug_mh.sv
// Multi-hart debug target: per-hart halt/resume/step FSM, debug data registers,
// and a one-cycle registered response to debug-module requests.
module riscv_i32_pipeline_debug_mh #(
  parameter int NUM_HARTS = 2,
  parameter int NUM_DATA  = 2
) (
  input  logic                    clk,
  input  logic                    clk__enable,
  input  logic                    reset_n,
  input  logic [5:0]              rv_select,
  input  logic                    debug_mst__valid,
  input  logic [5:0]              debug_mst__select,
  input  logic [5:0]              debug_mst__mask,
  input  logic [3:0]              debug_mst__op,
  input  logic [15:0]             debug_mst__arg,
  input  logic [31:0]             debug_mst__data,
  input  logic [NUM_HARTS-1:0]    debug_response__exec_valid,
  input  logic [NUM_HARTS-1:0]    debug_response__exec_halting,
  input  logic [NUM_HARTS-1:0]    debug_response__exec_dret,
  output logic [NUM_HARTS-1:0]    debug_control__valid,
  output logic [NUM_HARTS-1:0]    debug_control__kill_fetch,
  output logic [NUM_HARTS-1:0]    debug_control__halt_request,
  output logic [NUM_HARTS-1:0]    debug_control__fetch_dret,
  output logic [32*NUM_HARTS-1:0] debug_control__data,
  output logic                    debug_tgt__valid,
  output logic [5:0]              debug_tgt__selected,
  output logic                    debug_tgt__halted,
  output logic                    debug_tgt__resumed,
  output logic                    debug_tgt__hit_breakpoint,
  output logic                    debug_tgt__op_was_none,
  output logic [1:0]              debug_tgt__resp,
  output logic [31:0]             debug_tgt__data,
  output logic                    debug_tgt__attention,
  output logic [2*NUM_HARTS-1:0]  debug_state
);

  // Handshake: a request is accepted in the cycle debug_mst__valid=1 and
  // select matches a hart; no backpressure, the response follows one
  // enabled clock later with debug_tgt__valid=1 for exactly one cycle.

  typedef enum logic [1:0] {
    RUNNING  = 2'd0,
    HALT_REQ = 2'd1,
    HALTED   = 2'd2,
    RESUMING = 2'd3
  } hart_state_t;

  localparam logic [3:0] OP_NONE    = 4'd0;
  localparam logic [3:0] OP_CONTROL = 4'd1;
  localparam logic [3:0] OP_WRITE   = 4'd2;
  localparam logic [3:0] OP_READ    = 4'd3;
  localparam logic [1:0] RESP_OK    = 2'b00;
  localparam logic [1:0] RESP_ERR   = 2'b10;
  localparam logic [4:0] NUM_DATA_W = 5'(NUM_DATA);

  hart_state_t          state_q [NUM_HARTS];
  hart_state_t          state_d [NUM_HARTS];
  logic [31:0]          data_q  [NUM_HARTS][NUM_DATA];
  logic [31:0]          data_d  [NUM_HARTS][NUM_DATA];
  logic [NUM_HARTS-1:0] halt_req_q, halt_req_d, resume_req_q, resume_req_d;
  logic [NUM_HARTS-1:0] step_q, step_d, halted_q, halted_d;
  logic [NUM_HARTS-1:0] hit_bp_q, hit_bp_d, resumed_q, resumed_d, attn_q, attn_d;

  logic [5:0]           hart_sel [NUM_HARTS];
  logic [NUM_HARTS-1:0] hit, attn_sel;
  logic [3:0]           idx;
  logic                 idx_ok;
  logic                 unused_arg_bits;

  logic                 rsp_valid, rsp_halted, rsp_resumed, rsp_hit_bp, rsp_none;
  logic [5:0]           rsp_sel;
  logic [1:0]           rsp_resp;
  logic [31:0]          rsp_data;

  assign idx             = debug_mst__arg[3:0];
  assign idx_ok          = {1'b0, idx} < NUM_DATA_W;
  assign unused_arg_bits = ^debug_mst__arg[15:4];

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      hart_sel[h] = rv_select + 6'(h);
      hit[h]      = debug_mst__valid && (debug_mst__select == hart_sel[h]);
      attn_sel[h] = attn_q[h] && ((debug_mst__mask & hart_sel[h]) == debug_mst__select);
    end
  end

  // Per-hart next state. Attention clear from a request is applied first so
  // that any event setting attention in the same cycle overrides it.
  always_comb begin
    halt_req_d   = halt_req_q;
    resume_req_d = resume_req_q;
    step_d       = step_q;
    halted_d     = halted_q;
    hit_bp_d     = hit_bp_q;
    resumed_d    = resumed_q;
    attn_d       = attn_q;
    for (int h = 0; h < NUM_HARTS; h++) begin
      state_d[h] = state_q[h];
      for (int i = 0; i < NUM_DATA; i++) data_d[h][i] = data_q[h][i];
    end

    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hit[h]) begin
        attn_d[h] = 1'b0;
        if (debug_mst__op == OP_CONTROL) begin
          halt_req_d[h]   = debug_mst__arg[0];
          resume_req_d[h] = debug_mst__arg[1];
          step_d[h]       = debug_mst__arg[2];
        end
        if (debug_mst__op == OP_WRITE && idx_ok) begin
          for (int i = 0; i < NUM_DATA; i++)
            if (idx == 4'(i)) data_d[h][i] = debug_mst__data;
        end
      end

      if (resumed_q[h] && !resume_req_q[h]) begin
        resumed_d[h] = 1'b0;
        attn_d[h]    = 1'b1;
      end

      case (state_q[h])
        RUNNING: begin
          if (debug_response__exec_valid[h] && debug_response__exec_halting[h]) begin
            state_d[h]  = HALTED;
            halted_d[h] = 1'b1;
            hit_bp_d[h] = 1'b1;
            attn_d[h]   = 1'b1;
          end else if (halt_req_q[h]) begin
            state_d[h] = HALT_REQ;
          end
        end
        HALT_REQ: begin
          if (debug_response__exec_valid[h] && debug_response__exec_halting[h]) begin
            state_d[h]  = HALTED;
            halted_d[h] = 1'b1;
            attn_d[h]   = 1'b1;
          end
        end
        HALTED: begin
          // The !resumed guard stops a still-asserted resume from re-resuming.
          if (resume_req_q[h] && !resumed_q[h]) state_d[h] = RESUMING;
        end
        RESUMING: begin
          if (debug_response__exec_valid[h] && debug_response__exec_dret[h]) begin
            state_d[h]   = RUNNING;
            halted_d[h]  = 1'b0;
            hit_bp_d[h]  = 1'b0;
            resumed_d[h] = 1'b1;
            attn_d[h]    = 1'b1;
            if (step_q[h]) halt_req_d[h] = 1'b1;
          end
        end
        default: state_d[h] = RUNNING;
      endcase
    end
  end

  always_comb begin
    rsp_valid   = |hit;
    rsp_sel     = 6'd0;
    rsp_halted  = 1'b0;
    rsp_resumed = 1'b0;
    rsp_hit_bp  = 1'b0;
    rsp_none    = 1'b0;
    rsp_resp    = RESP_OK;
    rsp_data    = 32'd0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hit[h]) begin
        rsp_sel     = hart_sel[h];
        rsp_halted  = halted_q[h];
        rsp_resumed = resumed_q[h];
        rsp_hit_bp  = hit_bp_q[h];
        rsp_none    = (debug_mst__op == OP_NONE);
        case (debug_mst__op)
          OP_NONE, OP_CONTROL: rsp_resp = RESP_OK;
          OP_WRITE:            rsp_resp = idx_ok ? RESP_OK : RESP_ERR;
          OP_READ: begin
            rsp_resp = idx_ok ? RESP_OK : RESP_ERR;
            for (int i = 0; i < NUM_DATA; i++)
              if (idx_ok && idx == 4'(i)) rsp_data = data_q[h][i];
          end
          default:             rsp_resp = RESP_ERR;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halt_req_q   <= '0;
      resume_req_q <= '0;
      step_q       <= '0;
      halted_q     <= '0;
      hit_bp_q     <= '0;
      resumed_q    <= '0;
      attn_q       <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        state_q[h] <= RUNNING;
        for (int i = 0; i < NUM_DATA; i++) data_q[h][i] <= 32'd0;
      end
      debug_tgt__valid          <= 1'b0;
      debug_tgt__selected       <= 6'd0;
      debug_tgt__halted         <= 1'b0;
      debug_tgt__resumed        <= 1'b0;
      debug_tgt__hit_breakpoint <= 1'b0;
      debug_tgt__op_was_none    <= 1'b0;
      debug_tgt__resp           <= 2'b00;
      debug_tgt__data           <= 32'd0;
      debug_tgt__attention      <= 1'b0;
    end else if (clk__enable) begin
      halt_req_q   <= halt_req_d;
      resume_req_q <= resume_req_d;
      step_q       <= step_d;
      halted_q     <= halted_d;
      hit_bp_q     <= hit_bp_d;
      resumed_q    <= resumed_d;
      attn_q       <= attn_d;
      for (int h = 0; h < NUM_HARTS; h++) begin
        state_q[h] <= state_d[h];
        for (int i = 0; i < NUM_DATA; i++) data_q[h][i] <= data_d[h][i];
      end
      debug_tgt__valid          <= rsp_valid;
      debug_tgt__selected       <= rsp_sel;
      debug_tgt__halted         <= rsp_halted;
      debug_tgt__resumed        <= rsp_resumed;
      debug_tgt__hit_breakpoint <= rsp_hit_bp;
      debug_tgt__op_was_none    <= rsp_none;
      debug_tgt__resp           <= rsp_resp;
      debug_tgt__data           <= rsp_data;
      debug_tgt__attention      <= |attn_sel;
    end
  end

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      debug_control__valid[h]        = (state_q[h] != RUNNING);
      debug_control__kill_fetch[h]   = (state_q[h] == HALT_REQ) || (state_q[h] == HALTED);
      debug_control__halt_request[h] = (state_q[h] == HALT_REQ);
      debug_control__fetch_dret[h]   = (state_q[h] == RESUMING);
      debug_control__data[32*h +: 32] = data_q[h][0];
      debug_state[2*h +: 2]          = state_q[h];
    end
  end

endmodule

// File: tb/tb_riscv_i32_pipeline_debug_mh.sv
// Directed bench for riscv_i32_pipeline_debug_mh with two harts at base select 8.
module tb_riscv_i32_pipeline_debug_mh;
  localparam int NH = 2;
  localparam int ND = 2;

  logic          clk = 1'b0;
  logic          clk__enable;
  logic          reset_n;
  logic [5:0]    rv_select;
  logic          debug_mst__valid;
  logic [5:0]    debug_mst__select;
  logic [5:0]    debug_mst__mask;
  logic [3:0]    debug_mst__op;
  logic [15:0]   debug_mst__arg;
  logic [31:0]   debug_mst__data;
  logic [NH-1:0] exec_valid, exec_halting, exec_dret;
  logic [NH-1:0] ctl_valid, ctl_kill, ctl_halt, ctl_dret;
  logic [32*NH-1:0] ctl_data;
  logic          tgt_valid, tgt_halted, tgt_resumed, tgt_hit_bp, tgt_none, tgt_attn;
  logic [5:0]    tgt_sel;
  logic [1:0]    tgt_resp;
  logic [31:0]   tgt_data;
  logic [2*NH-1:0] dbg_state;
  logic [4*NH-1:0] ctrl;

  int checks = 0;
  int errors = 0;

  assign ctrl = {ctl_valid, ctl_kill, ctl_halt, ctl_dret};

  riscv_i32_pipeline_debug_mh #(.NUM_HARTS(NH), .NUM_DATA(ND)) dut (
    .clk                          (clk),
    .clk__enable                  (clk__enable),
    .reset_n                      (reset_n),
    .rv_select                    (rv_select),
    .debug_mst__valid             (debug_mst__valid),
    .debug_mst__select            (debug_mst__select),
    .debug_mst__mask              (debug_mst__mask),
    .debug_mst__op                (debug_mst__op),
    .debug_mst__arg               (debug_mst__arg),
    .debug_mst__data              (debug_mst__data),
    .debug_response__exec_valid   (exec_valid),
    .debug_response__exec_halting (exec_halting),
    .debug_response__exec_dret    (exec_dret),
    .debug_control__valid         (ctl_valid),
    .debug_control__kill_fetch    (ctl_kill),
    .debug_control__halt_request  (ctl_halt),
    .debug_control__fetch_dret    (ctl_dret),
    .debug_control__data          (ctl_data),
    .debug_tgt__valid             (tgt_valid),
    .debug_tgt__selected          (tgt_sel),
    .debug_tgt__halted            (tgt_halted),
    .debug_tgt__resumed           (tgt_resumed),
    .debug_tgt__hit_breakpoint    (tgt_hit_bp),
    .debug_tgt__op_was_none       (tgt_none),
    .debug_tgt__resp              (tgt_resp),
    .debug_tgt__data              (tgt_data),
    .debug_tgt__attention         (tgt_attn),
    .debug_state                  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic idle();
    debug_mst__valid  = 1'b0;
    debug_mst__select = 6'd0;
    debug_mst__mask   = 6'd0;
    debug_mst__op     = 4'd0;
    debug_mst__arg    = 16'd0;
    debug_mst__data   = 32'd0;
    exec_valid        = '0;
    exec_halting      = '0;
    exec_dret         = '0;
  endtask

  task automatic req(input logic [5:0] sel, input logic [3:0] op, input logic [15:0] arg,
                     input logic [31:0] dat, input logic [5:0] msk);
    debug_mst__valid  = 1'b1;
    debug_mst__select = sel;
    debug_mst__op     = op;
    debug_mst__arg    = arg;
    debug_mst__data   = dat;
    debug_mst__mask   = msk;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk__enable = 1'b1;
    reset_n     = 1'b0;
    rv_select   = 6'd8;
    idle();
    tick();
    tick();
    check("rst_tgt_valid", 64'(tgt_valid), 64'd0);
    check("rst_ctrl", 64'(ctrl), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_cdata", ctl_data, 64'd0);
    check("rst_attn", 64'(tgt_attn), 64'd0);
    reset_n = 1'b1;
    tick();

    // Clock enable low: request must be ignored
    clk__enable = 1'b0;
    req(6'd9, 4'd0, 16'd0, 32'd0, 6'd0);
    tick();
    check("cke_hold", 64'(tgt_valid), 64'd0);
    clk__enable = 1'b1;
    idle();
    tick();
    check("cke_state", 64'(dbg_state), 64'd0);

    // Halt request to hart 1
    req(6'd9, 4'd1, 16'h0001, 32'd0, 6'd0);
    tick();
    idle();
    check("ctl_valid", 64'(tgt_valid), 64'd1);
    check("ctl_sel", 64'(tgt_sel), 64'd9);
    check("ctl_resp", 64'(tgt_resp), 64'd0);
    check("ctl_none", 64'(tgt_none), 64'd0);
    tick();
    check("ctl_ctrl", 64'(ctrl), 64'({2'b10, 2'b10, 2'b10, 2'b00}));
    check("ctl_state", 64'(dbg_state), 64'(4'b0100));
    check("ctl_rsp_gone", 64'(tgt_valid), 64'd0);

    // Breakpoint halt on hart 0 while running
    exec_valid   = 2'b01;
    exec_halting = 2'b01;
    tick();
    idle();
    check("bp_state", 64'(dbg_state), 64'(4'b0110));
    check("bp_ctrl", 64'(ctrl), 64'({2'b11, 2'b11, 2'b10, 2'b00}));
    tick();
    check("bp_attn", 64'(tgt_attn), 64'd1);
    req(6'd8, 4'd0, 16'd0, 32'd0, 6'h3f);
    tick();
    idle();
    check("none_valid", 64'(tgt_valid), 64'd1);
    check("none_flag", 64'(tgt_none), 64'd1);
    check("none_sel", 64'(tgt_sel), 64'd8);
    check("none_halted", 64'(tgt_halted), 64'd1);
    check("none_hitbp", 64'(tgt_hit_bp), 64'd1);
    check("none_attn", 64'(tgt_attn), 64'd1);
    tick();
    check("attn_cleared", 64'(tgt_attn), 64'd0);

    // Data register write / read / bounds
    req(6'd8, 4'd2, 16'd1, 32'hDEADBEEF, 6'd0);
    tick();
    idle();
    check("wr_resp", 64'(tgt_resp), 64'd0);
    check("wr_data", 64'(tgt_data), 64'd0);
    req(6'd8, 4'd3, 16'd1, 32'd0, 6'd0);
    tick();
    idle();
    check("rd1_data", 64'(tgt_data), 64'hDEADBEEF);
    check("rd1_resp", 64'(tgt_resp), 64'd0);
    req(6'd8, 4'd3, 16'd5, 32'd0, 6'd0);
    tick();
    idle();
    check("rd5_data", 64'(tgt_data), 64'd0);
    check("rd5_resp", 64'(tgt_resp), 64'(2'b10));
    req(6'd9, 4'd2, 16'd0, 32'h12345678, 6'd0);
    tick();
    idle();
    check("wr_h1_cdata", ctl_data, {32'h12345678, 32'h0});
    req(6'd9, 4'd2, 16'd3, 32'hFFFFFFFF, 6'd0);
    tick();
    idle();
    check("wr3_resp", 64'(tgt_resp), 64'(2'b10));
    check("wr3_nowrite", ctl_data, {32'h12345678, 32'h0});
    req(6'd9, 4'd9, 16'd0, 32'd0, 6'd0);
    tick();
    idle();
    check("badop_resp", 64'(tgt_resp), 64'(2'b10));
    check("badop_state", 64'(dbg_state), 64'(4'b0110));

    // Resume with single-step on hart 0
    req(6'd8, 4'd1, 16'd6, 32'd0, 6'd0);
    tick();
    idle();
    check("rs_rsp_halted", 64'(tgt_halted), 64'd1);
    tick();
    check("rs_state", 64'(dbg_state), 64'(4'b0111));
    check("rs_ctrl", 64'(ctrl), 64'({2'b11, 2'b10, 2'b10, 2'b01}));
    exec_valid = 2'b01;
    exec_dret  = 2'b01;
    tick();
    idle();
    check("dret_state", 64'(dbg_state), 64'(4'b0100));
    req(6'd8, 4'd0, 16'd0, 32'd0, 6'd0);
    tick();
    idle();
    check("step_state", 64'(dbg_state), 64'(4'b0101));
    check("step_resumed", 64'(tgt_resumed), 64'd1);
    check("step_halted", 64'(tgt_halted), 64'd0);
    check("step_hitbp", 64'(tgt_hit_bp), 64'd0);
    exec_valid   = 2'b11;
    exec_halting = 2'b11;
    tick();
    idle();
    check("dual_state", 64'(dbg_state), 64'(4'b1010));
    req(6'd8, 4'd0, 16'd0, 32'd0, 6'd0);
    tick();
    idle();
    check("step_done_halted", 64'(tgt_halted), 64'd1);
    check("step_done_hitbp", 64'(tgt_hit_bp), 64'd0);
    req(6'd9, 4'd0, 16'd0, 32'd0, 6'd0);
    tick();
    idle();
    check("h1_halted", 64'(tgt_halted), 64'd1);
    check("h1_hitbp", 64'(tgt_hit_bp), 64'd0);

    // Reset while hart 1 is resuming with data held
    req(6'd9, 4'd1, 16'd2, 32'd0, 6'd0);
    tick();
    idle();
    tick();
    check("pre_rst_state", 64'(dbg_state), 64'(4'b1110));
    req(6'd8, 4'd3, 16'd1, 32'd0, 6'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ctrl", 64'(ctrl), 64'd0);
    check("arst_state", 64'(dbg_state), 64'd0);
    check("arst_cdata", ctl_data, 64'd0);
    check("arst_tgt_data", 64'(tgt_data), 64'd0);
    tick();
    tick();
    check("arst_no_rsp", 64'(tgt_valid), 64'd0);
    idle();
    reset_n = 1'b1;
    tick();
    req(6'd9, 4'd3, 16'd0, 32'd0, 6'd0);
    tick();
    idle();
    check("post_rst_valid", 64'(tgt_valid), 64'd1);
    check("post_rst_data", 64'(tgt_data), 64'd0);
    check("post_rst_resp", 64'(tgt_resp), 64'd0);
    req(6'd8, 4'd3, 16'd1, 32'd0, 6'd0);
    tick();
    idle();
    check("post_rst_h0d1", 64'(tgt_data), 64'd0);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_i32_pipeline_debug_mh.md
RISCV_I32_PIPELINE_DEBUG_MH -- requirements
Module: riscv_i32_pipeline_debug_mh

Interface
REQ-001 Parameter NUM_HARTS, default 2, range 1..4: number of pipeline harts served; hart h answers select rv_select+h.
REQ-002 Parameter NUM_DATA, default 2, range 1..4: number of 32-bit debug data registers per hart.
REQ-003 clk  in  1  single clock; all state changes on its rising edge when clk__enable=1.
REQ-004 clk__enable  in  1  clock enable.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 rv_select  in  6  base select; hart h select = rv_select+h (6-bit wrap).
REQ-007 debug_mst__valid/select[6]/mask[6]/op[4]/arg[16]/data[32]  in  request bundle from the debug module.
REQ-008 debug_response__exec_valid/exec_halting/exec_dret  in  NUM_HARTS each  per-hart execution reports.
REQ-009 debug_control__valid/kill_fetch/halt_request/fetch_dret  out  NUM_HARTS each  per-hart pipeline control.
REQ-010 debug_control__data  out  32*NUM_HARTS  per-hart data register 0.
REQ-011 debug_tgt__valid/selected[6]/halted/resumed/hit_breakpoint/op_was_none/resp[2]/data[32]/attention  out  response bundle.

Function
REQ-012 A request addresses hart h when debug_mst__valid=1 and debug_mst__select == rv_select+h; at most one hart matches.
REQ-013 op 0 (none): no state change; the response has op_was_none=1.
REQ-014 op 1 (control): hart h halt_req<=arg[0], resume_req<=arg[1], step<=arg[2].
REQ-015 op 2 (write): if arg[3:0] < NUM_DATA, data[arg[3:0]]<=debug_mst__data and resp=0; otherwise no write and resp=2'b10 (error).
REQ-016 op 3 (read): response data = data[arg[3:0]] and resp=0; index >= NUM_DATA gives data 0 and resp=2'b10.
REQ-017 Any other op: resp=2'b10, no state change.
REQ-018 Response latency is exactly 1 cycle: registered debug_tgt__valid=1 with selected, halted, resumed, hit_breakpoint, resp and data of the addressed hart; all zero otherwise.
REQ-019 Per-hart FSM states: RUNNING(0), HALT_REQ(1), HALTED(2), RESUMING(3).
REQ-020 RUNNING: halt_req -> HALT_REQ; exec_valid&exec_halting -> HALTED with halted=1, hit_breakpoint=1, attention=1. The exec event takes priority over halt_req.
REQ-021 HALT_REQ: exec_valid&exec_halting -> HALTED, halted=1, attention=1.
REQ-022 HALTED: resume_req & !resumed -> RESUMING.
REQ-023 RESUMING: exec_valid&exec_dret -> RUNNING with halted=0, hit_breakpoint=0, resumed=1, attention=1; if step=1, also force halt_req=1 so the hart halts after one instruction (single-step).
REQ-024 resumed=1 & resume_req=0 -> resumed<=0, attention<=1.
REQ-025 Control outputs: RUNNING all 0; HALT_REQ valid, kill_fetch, halt_request; HALTED valid, kill_fetch; RESUMING valid, fetch_dret.
REQ-026 Attention per hart is sticky and is cleared by any valid request to that hart. In the same cycle, set wins over clear.
REQ-027 Registered debug_tgt__attention = OR over harts h with (mask & (rv_select+h)) == select of that hart's attention.
REQ-028 Exec inputs to harts not in an exec-sensitive state are ignored; simultaneous events on different harts are processed independently.

Reset
REQ-029 While reset_n=0, all FSMs = RUNNING; all flags, data registers and step = 0; every output = 0.
REQ-030 If reset is asserted mid-operation (any state), the block returns to the REQ-029 state asynchronously, and no response is issued for an in-flight request.

Verification
REQ-031 Hart 1 at rv_select=8: op1 arg=1 at select 9 -> next cycle tgt valid, selected=9; control halt_request[1]=1, kill_fetch[1]=1; hart 0 control stays 0.
REQ-032 Exec_halting on hart 0 in RUNNING -> halted=1, hit_breakpoint=1, attention=1; a subsequent op0 read gives op_was_none=1 and clears attention.
REQ-033 Write data[1]=0xDEADBEEF, then read index 1 -> data 0xDEADBEEF, resp 0; read index 5 with NUM_DATA=2 -> data 0, resp 2'b10.
REQ-034 Halted hart, op1 arg=6 (resume+step), dret -> RUNNING, resumed=1; next cycle HALT_REQ; exec_halting -> HALTED with hit_breakpoint=0.
REQ-035 reset_n low while in RESUMING with data set -> all outputs 0 immediately; after release, read of data0 returns 0.
